hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 11 +
 rtl/hazard_perf_cnt.sv | 14 +
 rtl/hazard_ctrl.sv | 75 +++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: state encoding and default widths shared by the hazard controller
package hazard_pkg;
  localparam int DEF_REG_W = 5;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    IMEM_WAIT  = 2'd3
  } state_t;
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: saturating event counter with synchronous clear
module hazard_perf_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control FSM; perf counters enabled by HAZARD_PERF_CNT_EN
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W = DEF_REG_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_ready,
  input  logic             ID_EX_memread,
  input  logic [REG_W-1:0] ID_EX_rt,
  input  logic [REG_W-1:0] IF_ID_rs,
  input  logic [REG_W-1:0] IF_ID_rt,
  input  logic             EX_MEM_PCSrc,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);
  state_t state, nxt;
  logic   load_use;
  // bubble states suppress detection so each stall or flush costs exactly one cycle
  assign load_use = ID_EX_memread && ID_EX_rt != '0 &&
                    (ID_EX_rt == IF_ID_rs || ID_EX_rt == IF_ID_rt) &&
                    (state == RUN || state == IMEM_WAIT);
  assign ctrl_state = state;
  always_comb begin
    nxt          = RUN;
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    if (!rst_n) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      {IF_ID_flush, ID_EX_flush, EX_MEM_flush} = 3'b111;
    end else if (EX_MEM_PCSrc) begin
      {IF_ID_flush, ID_EX_flush, EX_MEM_flush} = 3'b111;
      nxt = FLUSH;
    end else if (!imem_ready) begin
      PC_write    = 1'b0;
      IF_ID_flush = 1'b1;
      nxt         = IMEM_WAIT;
    end else if (load_use) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
      nxt         = LOAD_STALL;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else state <= nxt;
  end
`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc, flush_inc, wait_inc;
  assign flush_inc = rst_n && EX_MEM_PCSrc;
  assign wait_inc  = rst_n && !EX_MEM_PCSrc && !imem_ready;
  assign stall_inc = rst_n && !EX_MEM_PCSrc && imem_ready && load_use;
  hazard_perf_cnt #(.W(CNT_W)) u_stall (.clk(clk), .clr(!rst_n), .inc(stall_inc), .cnt(stall_cnt));
  hazard_perf_cnt #(.W(CNT_W)) u_flush (.clk(clk), .clr(!rst_n), .inc(flush_inc), .cnt(flush_cnt));
  hazard_perf_cnt #(.W(CNT_W)) u_wait  (.clk(clk), .clr(!rst_n), .inc(wait_inc),  .cnt(wait_cnt));
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign wait_cnt  = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl outputs, state and counters
module tb_hazard_ctrl;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, imem_ready, ID_EX_memread, EX_MEM_PCSrc;
  logic [4:0] ID_EX_rt, IF_ID_rs, IF_ID_rt;
  logic PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush;
  logic [1:0] ctrl_state;
  logic [15:0] stall_cnt, flush_cnt, wait_cnt;
  logic s_pcw, s_ifw, s_iff, s_idf, s_exf;
  logic [1:0] s_state, s_stall, s_flush, s_wait;
  logic [4:0] outs;
  int n_checks = 0;
  int n_fail = 0;

  assign outs = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush};

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .ID_EX_memread(ID_EX_memread),
    .ID_EX_rt(ID_EX_rt), .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .EX_MEM_PCSrc(EX_MEM_PCSrc),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush), .ctrl_state(ctrl_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .ID_EX_memread(ID_EX_memread),
    .ID_EX_rt(ID_EX_rt), .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .EX_MEM_PCSrc(EX_MEM_PCSrc),
    .PC_write(s_pcw), .IF_ID_write(s_ifw), .IF_ID_flush(s_iff),
    .ID_EX_flush(s_idf), .EX_MEM_flush(s_exf), .ctrl_state(s_state),
    .stall_cnt(s_stall), .flush_cnt(s_flush), .wait_cnt(s_wait)
  );

  task automatic drive(input logic b, input logic r, input logic m,
                       input logic [4:0] e, input logic [4:0] s, input logic [4:0] t);
    EX_MEM_PCSrc = b; imem_ready = r; ID_EX_memread = m;
    ID_EX_rt = e; IF_ID_rs = s; IF_ID_rt = t;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    n_checks++; if (outs !== 5'b00111) begin n_fail++; $display("FAIL reset_outs got=%b want=%b", outs, 5'b00111); end
    tick;
    n_checks++; if (ctrl_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d want=0", ctrl_state); end
    n_checks++; if ({stall_cnt, flush_cnt, wait_cnt} !== 48'd0) begin n_fail++; $display("FAIL reset_cnts got=%0d/%0d/%0d want=0/0/0", stall_cnt, flush_cnt, wait_cnt); end
    n_checks++; if (s_flush !== 2'd0) begin n_fail++; $display("FAIL reset_sat_cnt got=%0d want=0", s_flush); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (outs !== 5'b11000) begin n_fail++; $display("FAIL release_outs got=%b want=%b", outs, 5'b11000); end
  endtask

  task automatic test_load_use;
    drive(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0);
    n_checks++; if (outs !== 5'b00010) begin n_fail++; $display("FAIL lu_rs_outs got=%b want=%b", outs, 5'b00010); end
    tick;
    n_checks++; if (ctrl_state !== 2'd1) begin n_fail++; $display("FAIL lu_state got=%0d want=1", ctrl_state); end
    n_checks++; if (outs !== 5'b11000) begin n_fail++; $display("FAIL lu_bubble_outs got=%b want=%b", outs, 5'b11000); end
    tick;
    n_checks++; if (ctrl_state !== 2'd0) begin n_fail++; $display("FAIL lu_back_run got=%0d want=0", ctrl_state); end
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    n_checks++; if (outs !== 5'b11000) begin n_fail++; $display("FAIL lu_run_outs got=%b want=%b", outs, 5'b11000); end
    n_checks++; if (stall_cnt !== (PERF ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL lu_stall_cnt got=%0d want=%0d", stall_cnt, PERF ? 1 : 0); end
    drive(1'b0, 1'b1, 1'b1, 5'd7, 5'd3, 5'd7);
    n_checks++; if (outs !== 5'b00010) begin n_fail++; $display("FAIL lu_rt_outs got=%b want=%b", outs, 5'b00010); end
    tick;
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    tick;
    n_checks++; if (stall_cnt !== (PERF ? 16'd2 : 16'd0)) begin n_fail++; $display("FAIL lu_stall_cnt2 got=%0d want=%0d", stall_cnt, PERF ? 2 : 0); end
  endtask

  task automatic test_no_stall;
    drive(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    n_checks++; if (outs !== 5'b11000) begin n_fail++; $display("FAIL r0_outs got=%b want=%b", outs, 5'b11000); end
    tick;
    n_checks++; if (ctrl_state !== 2'd0) begin n_fail++; $display("FAIL r0_state got=%0d want=0", ctrl_state); end
    drive(1'b0, 1'b1, 1'b0, 5'd5, 5'd5, 5'd5);
    n_checks++; if (outs !== 5'b11000) begin n_fail++; $display("FAIL noload_outs got=%b want=%b", outs, 5'b11000); end
    drive(1'b0, 1'b1, 1'b1, 5'd5, 5'd6, 5'd7);
    n_checks++; if (outs !== 5'b11000) begin n_fail++; $display("FAIL nomatch_outs got=%b want=%b", outs, 5'b11000); end
    tick;
    n_checks++; if (stall_cnt !== (PERF ? 16'd2 : 16'd0)) begin n_fail++; $display("FAIL nostall_cnt got=%0d want=%0d", stall_cnt, PERF ? 2 : 0); end
  endtask

  task automatic test_branch;
    drive(1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0);
    n_checks++; if (outs !== 5'b11111) begin n_fail++; $display("FAIL br_outs got=%b want=%b", outs, 5'b11111); end
    tick;
    n_checks++; if (ctrl_state !== 2'd2) begin n_fail++; $display("FAIL br_state got=%0d want=2", ctrl_state); end
    n_checks++; if (flush_cnt !== (PERF ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL br_flush_cnt got=%0d want=%0d", flush_cnt, PERF ? 1 : 0); end
    drive(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0);
    n_checks++; if (outs !== 5'b11000) begin n_fail++; $display("FAIL br_suppress_outs got=%b want=%b", outs, 5'b11000); end
    tick;
    n_checks++; if (ctrl_state !== 2'd0) begin n_fail++; $display("FAIL br_back_run got=%0d want=0", ctrl_state); end
    n_checks++; if (stall_cnt !== (PERF ? 16'd2 : 16'd0)) begin n_fail++; $display("FAIL br_stall_cnt got=%0d want=%0d", stall_cnt, PERF ? 2 : 0); end
    drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    tick;
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    n_checks++; if (outs !== 5'b11111) begin n_fail++; $display("FAIL br_in_flush_outs got=%b want=%b", outs, 5'b11111); end
    tick;
    n_checks++; if (ctrl_state !== 2'd2) begin n_fail++; $display("FAIL br_in_flush_state got=%0d want=2", ctrl_state); end
    n_checks++; if (flush_cnt !== (PERF ? 16'd3 : 16'd0)) begin n_fail++; $display("FAIL br_flush_cnt3 got=%0d want=%0d", flush_cnt, PERF ? 3 : 0); end
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    tick;
  endtask

  task automatic test_imem_wait;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      n_checks++; if (outs !== 5'b01100) begin n_fail++; $display("FAIL wait_outs cyc%0d got=%b want=%b", i, outs, 5'b01100); end
      tick;
      n_checks++; if (ctrl_state !== 2'd3) begin n_fail++; $display("FAIL wait_state cyc%0d got=%0d want=3", i, ctrl_state); end
    end
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    n_checks++; if (outs !== 5'b11000) begin n_fail++; $display("FAIL wait_exit_outs got=%b want=%b", outs, 5'b11000); end
    tick;
    n_checks++; if (ctrl_state !== 2'd0) begin n_fail++; $display("FAIL wait_exit_state got=%0d want=0", ctrl_state); end
    n_checks++; if (wait_cnt !== (PERF ? 16'd3 : 16'd0)) begin n_fail++; $display("FAIL wait_cnt got=%0d want=%0d", wait_cnt, PERF ? 3 : 0); end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick;
    drive(1'b0, 1'b1, 1'b1, 5'd9, 5'd1, 5'd9);
    n_checks++; if (outs !== 5'b00010) begin n_fail++; $display("FAIL wait_exit_lu_outs got=%b want=%b", outs, 5'b00010); end
    tick;
    n_checks++; if (ctrl_state !== 2'd1) begin n_fail++; $display("FAIL wait_exit_lu_state got=%0d want=1", ctrl_state); end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick;
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    n_checks++; if (outs !== 5'b11111) begin n_fail++; $display("FAIL wait_branch_outs got=%b want=%b", outs, 5'b11111); end
    tick;
    n_checks++; if (ctrl_state !== 2'd2) begin n_fail++; $display("FAIL wait_branch_state got=%0d want=2", ctrl_state); end
    n_checks++; if ({stall_cnt, flush_cnt, wait_cnt} !== (PERF ? {16'd3, 16'd4, 16'd5} : 48'd0)) begin n_fail++; $display("FAIL wait_all_cnts got=%0d/%0d/%0d want=%0d/%0d/%0d", stall_cnt, flush_cnt, wait_cnt, PERF ? 3 : 0, PERF ? 4 : 0, PERF ? 5 : 0); end
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    tick;
  endtask

  task automatic test_reset_mid_op;
    drive(1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd4);
    tick;
    n_checks++; if (ctrl_state !== 2'd1) begin n_fail++; $display("FAIL rst_stall_entry got=%0d want=1", ctrl_state); end
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 5'd4, 5'd4, 5'd4);
    n_checks++; if (outs !== 5'b00111) begin n_fail++; $display("FAIL rst_stall_outs got=%b want=%b", outs, 5'b00111); end
    tick;
    n_checks++; if (ctrl_state !== 2'd0) begin n_fail++; $display("FAIL rst_stall_state got=%0d want=0", ctrl_state); end
    n_checks++; if ({stall_cnt, flush_cnt, wait_cnt} !== 48'd0) begin n_fail++; $display("FAIL rst_stall_cnts got=%0d/%0d/%0d want=0/0/0", stall_cnt, flush_cnt, wait_cnt); end
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    n_checks++; if (outs !== 5'b11000) begin n_fail++; $display("FAIL rst_stall_release_outs got=%b want=%b", outs, 5'b11000); end
    tick;
    drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    tick;
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    n_checks++; if (outs !== 5'b00111) begin n_fail++; $display("FAIL rst_flush_outs got=%b want=%b", outs, 5'b00111); end
    tick;
    rst_n = 1'b1;
    #1;
    n_checks++; if (ctrl_state !== 2'd0 || outs !== 5'b11000) begin n_fail++; $display("FAIL rst_flush_release got=%0d/%b want=0/%b", ctrl_state, outs, 5'b11000); end
    n_checks++; if (flush_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_flush_cnt got=%0d want=0", flush_cnt); end
  endtask

  task automatic test_saturation;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      tick;
      n_checks++; if (s_flush !== (PERF ? 2'((i > 3) ? 3 : i) : 2'd0)) begin n_fail++; $display("FAIL sat_flush br%0d got=%0d want=%0d", i, s_flush, PERF ? ((i > 3) ? 3 : i) : 0); end
    end
    n_checks++; if (flush_cnt !== (PERF ? 16'd5 : 16'd0)) begin n_fail++; $display("FAIL wide_flush_cnt got=%0d want=%0d", flush_cnt, PERF ? 5 : 0); end
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    tick;
  endtask

  initial begin
    test_reset;
    test_load_use;
    test_no_stall;
    test_branch;
    test_imem_wait;
    test_reset_mid_op;
    test_saturation;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
